// File: rtl/scratchpad_bank_if.sv
// Single-port scratchpad bank interface: controller drives strobes/address/write data,
// memory returns read data one cycle after ren.
interface scratchpad_bank_if #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 32
);
  logic          wen;
  logic          ren;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport ctrl (output wen, ren, addr, wdata, input rdata);
  modport mem  (input wen, ren, addr, wdata, output rdata);
endinterface

// File: rtl/spm_sram_wrapper.sv
// Single-port SRAM bank behind scratchpad_bank_if; registered read, valid one cycle after ren.
module spm_sram_wrapper #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned DW    = 32
) (
  input  logic             i_clk,
  scratchpad_bank_if.mem   bank
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (bank.wen) r_mem[bank.addr] <= bank.wdata;
    if (bank.ren) r_rdata <= r_mem[bank.addr];
  end

  assign bank.rdata = r_rdata;

endmodule

// File: rtl/spm_read_ctrl.sv
// Scratchpad egress: collects a packet from the mesh FIFO into an SRAM bank, then
// streams it off-chip MSB-first as DBUS_WIDTH beats with a valid/ready handshake.
module spm_read_ctrl #(
  parameter int unsigned BANK_SIZE      = 512,
  parameter int unsigned SRAM_WORD_SIZE = 32,
  parameter int unsigned DBUS_WIDTH     = 32,
  localparam int unsigned NUM_BEATS     = SRAM_WORD_SIZE / DBUS_WIDTH,
  localparam int unsigned AW            = $clog2(BANK_SIZE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [AW-1:0]             num_words,
  input  logic [SRAM_WORD_SIZE-1:0] fifo_rdata,
  input  logic                      fifo_empty,
  output logic                      dequeue,
  output logic [DBUS_WIDTH-1:0]     dbus_out,
  output logic                      dbus_valid,
  input  logic                      dbus_ready,
  output logic                      busy,
  output logic                      pkt_egress_fin
);

  localparam int unsigned BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BEATS - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_e;

  state_e                    r_state, w_state_nxt;
  logic [AW-1:0]             r_wr_cnt, r_rd_cnt, r_wr_addr, r_rd_addr;
  logic [BW-1:0]             r_beat;
  logic                      r_inflight, r_rd_done, r_valid, r_fin;
  logic [SRAM_WORD_SIZE-1:0] r_word;
  logic                      w_ren, w_hs, w_last_hs;

  scratchpad_bank_if #(.AW(AW), .DW(SRAM_WORD_SIZE)) u_bank ();

  spm_sram_wrapper #(
    .DEPTH (BANK_SIZE),
    .DW    (SRAM_WORD_SIZE)
  ) u_sram (
    .i_clk (clk),
    .bank  (u_bank)
  );

  assign w_hs      = r_valid && dbus_ready;
  assign w_last_hs = w_hs && (r_beat == LAST_BEAT);

  always_comb begin
    w_state_nxt = r_state;
    dequeue     = 1'b0;
    w_ren       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_state_nxt = COLLECT;
      end
      COLLECT: begin
        dequeue = !fifo_empty;
        if (dequeue && (r_wr_cnt == '0)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        // Refill only when the word register frees up this cycle, keeping one read in flight.
        w_ren = !r_inflight && !r_rd_done && (!r_valid || w_last_hs);
        if (w_last_hs && (r_rd_cnt == '0)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign u_bank.wen   = dequeue;
  assign u_bank.ren   = w_ren;
  assign u_bank.addr  = dequeue ? r_wr_addr : r_rd_addr;
  assign u_bank.wdata = fifo_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_beat     <= '0;
      r_inflight <= 1'b0;
      r_rd_done  <= 1'b0;
      r_valid    <= 1'b0;
      r_fin      <= 1'b0;
      r_word     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_ren;
      if ((r_state == IDLE) && start) begin
        r_wr_cnt  <= num_words;
        r_rd_cnt  <= num_words;
        r_wr_addr <= '0;
        r_rd_addr <= '0;
        r_beat    <= '0;
        r_rd_done <= 1'b0;
        r_fin     <= 1'b0;
      end
      if (dequeue) begin
        r_wr_addr <= r_wr_addr + AW'(1);
        r_wr_cnt  <= r_wr_cnt - AW'(1);
      end
      if (w_ren) begin
        r_rd_addr <= r_rd_addr + AW'(1);
        // wr_addr ends one past the last word (wraps to 0 for a full bank)
        if (r_rd_addr == r_wr_addr - AW'(1)) r_rd_done <= 1'b1;
      end
      if (r_inflight) begin
        r_word  <= u_bank.rdata;
        r_valid <= 1'b1;
        r_beat  <= '0;
      end else if (w_hs) begin
        r_word <= r_word << DBUS_WIDTH;
        if (r_beat == LAST_BEAT) begin
          r_beat   <= '0;
          r_valid  <= 1'b0;
          r_rd_cnt <= r_rd_cnt - AW'(1);
          if (r_rd_cnt == '0) r_fin <= 1'b1;
        end else begin
          r_beat <= r_beat + BW'(1);
        end
      end
    end
  end

  assign dbus_out       = r_word[SRAM_WORD_SIZE-1 -: DBUS_WIDTH];
  assign dbus_valid     = r_valid;
  assign busy           = (r_state != IDLE);
  assign pkt_egress_fin = r_fin;

endmodule

// File: tb/tb_spm_read_ctrl.sv
// Drives two egress controllers (32-bit and 16-bit bus) from one FIFO model and
// checks dequeues and bus beats against a packet-level reference.
module tb_spm_read_ctrl;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] num_words = '0;
  logic [31:0]   fifo_rdata = '0;
  logic          fifo_empty = 1'b1;
  logic          dbus_ready = 1'b1;
  logic          deq_a, val_a, busy_a, fin_a;
  logic [31:0]   out_a;
  logic          deq_b, val_b, busy_b, fin_b;
  logic [15:0]   out_b;

  always #5 clk = ~clk;

  spm_read_ctrl #(.BANK_SIZE(512), .SRAM_WORD_SIZE(32), .DBUS_WIDTH(32)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words), .fifo_rdata(fifo_rdata),
    .fifo_empty(fifo_empty), .dequeue(deq_a), .dbus_out(out_a), .dbus_valid(val_a),
    .dbus_ready(dbus_ready), .busy(busy_a), .pkt_egress_fin(fin_a)
  );

  spm_read_ctrl #(.BANK_SIZE(512), .SRAM_WORD_SIZE(32), .DBUS_WIDTH(16)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words), .fifo_rdata(fifo_rdata),
    .fifo_empty(fifo_empty), .dequeue(deq_b), .dbus_out(out_b), .dbus_valid(val_b),
    .dbus_ready(dbus_ready), .busy(busy_b), .pkt_egress_fin(fin_b)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] pkt[$];
  logic [31:0] fq[$];
  logic [31:0] qa[$];
  logic [15:0] qb[$];
  int m_left = 0, m_n = 0, popped = 0;
  int gap_at = -1, gap_len = 0, gap_cnt = 0;
  bit rand_ready = 1'b0;
  int deq_seen_a = 0, deq_seen_b = 0, beats_a = 0, beats_b = 0;
  logic pv_a = 1'b0, pr_a = 1'b0, pv_b = 1'b0, pr_b = 1'b0;
  logic [31:0] po_a = '0;
  logic [15:0] po_b = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, then observe what the next rising edge does.
  task automatic cycle(input logic st);
    logic exp_deq;
    bit   accept;
    @(negedge clk);
    start      = st;
    fifo_empty = (fq.size() == 0) || (gap_cnt > 0);
    if (fifo_empty) fifo_rdata = $urandom;
    else            fifo_rdata = fq[0];
    dbus_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    accept  = st && (m_left == 0) && (qa.size() == 0) && (qb.size() == 0);
    exp_deq = (m_left > 0) && !fifo_empty;
    chk("dequeue_a", deq_a, exp_deq);
    chk("dequeue_b", deq_b, exp_deq);
    deq_seen_a += deq_a;
    deq_seen_b += deq_b;
    if (pv_a && !pr_a) begin
      chk("hold_valid_a", val_a, 1'b1);
      chk("hold_out_a", out_a, po_a);
    end
    if (pv_b && !pr_b) begin
      chk("hold_valid_b", val_b, 1'b1);
      chk("hold_out_b", out_b, po_b);
    end
    if (val_a && dbus_ready) begin
      if (qa.size() == 0) chk("extra_beat_a", val_a, 1'b0);
      else begin
        chk("beat_a", out_a, qa.pop_front());
        beats_a++;
      end
    end
    if (val_b && dbus_ready) begin
      if (qb.size() == 0) chk("extra_beat_b", val_b, 1'b0);
      else begin
        chk("beat_b", out_b, qb.pop_front());
        beats_b++;
      end
    end
    pv_a = val_a; pr_a = dbus_ready; po_a = out_a;
    pv_b = val_b; pr_b = dbus_ready; po_b = out_b;
    if (exp_deq) begin
      void'(fq.pop_front());
      m_left--;
      popped++;
      if (popped == gap_at) gap_cnt = gap_len;
    end else if (gap_cnt > 0) begin
      gap_cnt--;
    end
    if (accept) begin
      m_n = pkt.size();
      m_left = m_n;
      popped = 0;
      deq_seen_a = 0; deq_seen_b = 0; beats_a = 0; beats_b = 0;
      foreach (pkt[i]) begin
        qa.push_back(pkt[i]);
        qb.push_back(pkt[i][31:16]);
        qb.push_back(pkt[i][15:0]);
      end
    end
  endtask

  task automatic send(input bit rr, input int gat, input int glen);
    fq = pkt;
    fq.push_back($urandom);
    fq.push_back($urandom);
    num_words  = AW'(pkt.size() - 1);
    rand_ready = rr;
    gap_at = gat; gap_len = glen; gap_cnt = 0;
    cycle(1'b1);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_a_after_start", busy_a, 1'b1);
    chk("busy_b_after_start", busy_b, 1'b1);
    chk("fin_a_cleared", fin_a, 1'b0);
    chk("fin_b_cleared", fin_b, 1'b0);
  endtask

  task automatic wait_done(input int maxc, input bit poke);
    for (int i = 0; i < maxc; i++) begin
      if ((m_left == 0) && (qa.size() == 0) && (qb.size() == 0)) break;
      if (poke && (i % 7 == 3) && ((m_left > 0) || (qa.size() > 0))) begin
        num_words = AW'($urandom);
        cycle(1'b1);
      end else begin
        cycle(1'b0);
      end
    end
    chk("drained_in_time", 32'((m_left == 0) && (qa.size() == 0) && (qb.size() == 0)), 1);
    cycle(1'b0);
    cycle(1'b0);
    chk("words_dequeued_a", deq_seen_a, m_n);
    chk("words_dequeued_b", deq_seen_b, m_n);
    chk("beats_a", beats_a, m_n);
    chk("beats_b", beats_b, 2 * m_n);
    chk("busy_a_end", busy_a, 1'b0);
    chk("busy_b_end", busy_b, 1'b0);
    chk("fin_a_end", fin_a, 1'b1);
    chk("fin_b_end", fin_b, 1'b1);
    chk("valid_a_end", val_a, 1'b0);
    chk("valid_b_end", val_b, 1'b0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_dequeue"}, {deq_a, deq_b}, 2'b00);
    chk({tag, "_valid"}, {val_a, val_b}, 2'b00);
    chk({tag, "_busy"}, {busy_a, busy_b}, 2'b00);
    chk({tag, "_fin"}, {fin_a, fin_b}, 2'b00);
    chk({tag, "_out_a"}, out_a, 32'h0);
    chk({tag, "_out_b"}, out_b, 32'h0);
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    reset_checks("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cycle(1'b0);
    reset_checks("idle");

    // Basic 32-bit case: four back-to-back words.
    pkt = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
    send(1'b0, -1, 0);
    wait_done(200, 1'b0);

    // Two words split into 16-bit beats on the narrow instance.
    pkt = {32'h1111_2222, 32'h3333_4444};
    send(1'b0, -1, 0);
    wait_done(200, 1'b0);

    // FIFO runs dry for five cycles after three words.
    pkt.delete();
    for (int i = 0; i < 8; i++) pkt.push_back($urandom);
    send(1'b0, 3, 5);
    wait_done(300, 1'b0);

    // Sink back-pressure toggled at random.
    pkt.delete();
    for (int i = 0; i < 12; i++) pkt.push_back($urandom);
    send(1'b1, -1, 0);
    wait_done(600, 1'b0);

    // Reset in the middle of draining.
    pkt.delete();
    for (int i = 0; i < 6; i++) pkt.push_back($urandom);
    send(1'b0, -1, 0);
    for (int i = 0; i < 200; i++) begin
      if (beats_a >= 2) break;
      cycle(1'b0);
    end
    chk("two_beats_before_reset", 32'(beats_a >= 2), 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    reset_checks("mid_drain_reset");
    fq.delete(); qa.delete(); qb.delete();
    m_left = 0; gap_cnt = 0;
    pv_a = 1'b0; pv_b = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pkt = {32'h5A5A_5A5A};
    send(1'b0, -1, 0);
    wait_done(100, 1'b0);

    // Full bank with incrementing data and start pulses while busy.
    pkt.delete();
    for (int i = 0; i < 512; i++) pkt.push_back(32'h1000_0000 + 32'(i));
    send(1'b0, -1, 0);
    wait_done(5000, 1'b1);

    // A few random packets with random gaps and back-pressure.
    for (int p = 0; p < 3; p++) begin
      pkt.delete();
      for (int i = 0; i < int'($urandom_range(1, 40)); i++) pkt.push_back($urandom);
      send(1'b1, int'($urandom_range(1, 5)), int'($urandom_range(1, 4)));
      wait_done(1000, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
